// File: rtl/ascon_op_sequencer.sv
// ascon_op_sequencer
// Control FSM for the Ascon datapath. Walks init, p^a / p^b permutation
// rounds, key and domain-separation XORs, per-block absorb and hash squeeze,
// emitting one-cycle strobes to the 320-bit state datapath. Block data is
// exchanged over a blk_req/blk_valid handshake; squeezed blocks over
// squeeze/sq_ack.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   op_mode         001 enc, 010 dec, 011 hash, 100 perm-only
//   op_start        start request, sampled only in IDLE
//   ad_blocks       associated-data block count (0 allowed)
//   msg_blocks      message block count, >=1 except perm-only
//   blk_valid       data block present for the current blk_req
//   sq_ack          squeezed block consumed
//   abort           abort request (active only with ASCON_SEQ_ABORT_EN)
//   state_load, perm_en, round_idx, key_xor_tail, key_xor_head, dsep_xor,
//   absorb_ad, absorb_msg   datapath strobes
//   blk_req, squeeze        handshake levels
//   blk_idx                 current AD/msg/squeeze block index
//   busy, done, err         status
//
// Build option: define ASCON_SEQ_ABORT_EN to make the abort input effective.
//
// state      | meaning
// IDLE       | waiting for op_start
// INIT       | load IV||K||N (hash: IV||0)
// PA         | initial p^a rounds (also the whole perm-only operation)
// KTAIL      | XOR key into the tail of the state after init
// AD_WAIT    | waiting for an AD block
// PB_AD      | p^b after an AD block
// DSEP       | domain-separation XOR
// MSG_WAIT   | waiting for a msg block
// PB_MSG     | p^b after a non-final AEAD msg block
// MSG_PA     | p^a after a hash msg block
// KHEAD      | key XOR before finalization
// PA_FIN     | finalization p^a
// KTAIL_FIN  | key XOR after finalization (tag)
// SQ_WAIT    | hash output block presented until sq_ack
// SQ_PA      | p^a between squeeze blocks
// DONE       | one-cycle completion pulse

module ascon_op_sequencer #(
    parameter int A_ROUNDS = 12,
    parameter int B_ROUNDS = 6,
    parameter int BLK_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op_mode,
    input  logic             op_start,
    input  logic [BLK_W-1:0] ad_blocks,
    input  logic [BLK_W-1:0] msg_blocks,
    input  logic             blk_valid,
    input  logic             sq_ack,
    input  logic             abort,
    output logic             state_load,
    output logic             perm_en,
    output logic [3:0]       round_idx,
    output logic             key_xor_tail,
    output logic             key_xor_head,
    output logic             dsep_xor,
    output logic             blk_req,
    output logic             absorb_ad,
    output logic             absorb_msg,
    output logic             squeeze,
    output logic [BLK_W-1:0] blk_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_PA, S_KTAIL, S_AD_WAIT, S_PB_AD, S_DSEP, S_MSG_WAIT,
        S_PB_MSG, S_MSG_PA, S_KHEAD, S_PA_FIN, S_KTAIL_FIN, S_SQ_WAIT, S_SQ_PA,
        S_DONE
    } state_t;

    localparam logic [2:0] MODE_ENC  = 3'b001;
    localparam logic [2:0] MODE_DEC  = 3'b010;
    localparam logic [2:0] MODE_HASH = 3'b011;
    localparam logic [2:0] MODE_PERM = 3'b100;

    // Round counters run down to 0; round_idx = 11 - rounds_left gives the
    // ascending constant index 12-N .. 11.
    localparam logic [3:0] A_LOAD = 4'(A_ROUNDS - 1);
    localparam logic [3:0] B_LOAD = 4'(B_ROUNDS - 1);
    localparam logic [BLK_W-1:0] SQ_LAST = BLK_W'(3);

    state_t           state_q, state_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [BLK_W-1:0] blk_idx_q, blk_idx_d;
    logic [2:0]       mode_q, mode_d;
    logic [BLK_W-1:0] ad_cnt_q, ad_cnt_d;
    logic [BLK_W-1:0] msg_cnt_q, msg_cnt_d;
    logic             err_q, err_d;

    logic             abort_act;
    logic             start_legal;
    logic             msg_last;

`ifdef ASCON_SEQ_ABORT_EN
    assign abort_act = abort && (state_q != S_IDLE);
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_act    = 1'b0;
`endif

    always_comb begin
        start_legal = 1'b0;
        case (op_mode)
            MODE_ENC, MODE_DEC, MODE_HASH: start_legal = (msg_blocks != '0);
            MODE_PERM:                     start_legal = 1'b1;
            default:                       start_legal = 1'b0;
        endcase
    end

    // Widened compare so msg_cnt = 2^BLK_W-1 cannot wrap.
    assign msg_last = ({1'b0, blk_idx_q} + 1'b1) == {1'b0, msg_cnt_q};

    always_comb begin
        state_d      = state_q;
        rnd_d        = rnd_q;
        blk_idx_d    = blk_idx_q;
        mode_d       = mode_q;
        ad_cnt_d     = ad_cnt_q;
        msg_cnt_d    = msg_cnt_q;
        err_d        = 1'b0;

        state_load   = 1'b0;
        perm_en      = 1'b0;
        round_idx    = 4'd0;
        key_xor_tail = 1'b0;
        key_xor_head = 1'b0;
        dsep_xor     = 1'b0;
        blk_req      = 1'b0;
        absorb_ad    = 1'b0;
        absorb_msg   = 1'b0;
        squeeze      = 1'b0;
        done         = 1'b0;
        busy         = (state_q != S_IDLE) && (state_q != S_DONE);

        case (state_q)
            S_IDLE: begin
                blk_idx_d = '0;
                if (op_start) begin
                    if (start_legal) begin
                        mode_d    = op_mode;
                        ad_cnt_d  = ad_blocks;
                        msg_cnt_d = msg_blocks;
                        if (op_mode == MODE_PERM) begin
                            state_d = S_PA;
                            rnd_d   = A_LOAD;
                        end else begin
                            state_d = S_INIT;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_INIT: begin
                state_load = 1'b1;
                state_d    = S_PA;
                rnd_d      = A_LOAD;
            end
            S_PA: begin
                perm_en   = 1'b1;
                round_idx = 4'd11 - rnd_q;
                rnd_d     = rnd_q - 4'd1;
                if (rnd_q == 4'd0) begin
                    rnd_d = 4'd0;
                    case (mode_q)
                        MODE_PERM: state_d = S_DONE;
                        MODE_HASH: begin
                            state_d   = S_MSG_WAIT;
                            blk_idx_d = '0;
                        end
                        default:   state_d = S_KTAIL;
                    endcase
                end
            end
            S_KTAIL: begin
                key_xor_tail = 1'b1;
                blk_idx_d    = '0;
                state_d      = (ad_cnt_q == '0) ? S_DSEP : S_AD_WAIT;
            end
            S_AD_WAIT: begin
                blk_req = 1'b1;
                if (blk_valid && !abort_act) begin
                    absorb_ad = 1'b1;
                    blk_idx_d = blk_idx_q + 1'b1;
                    state_d   = S_PB_AD;
                    rnd_d     = B_LOAD;
                end
            end
            S_PB_AD: begin
                perm_en   = 1'b1;
                round_idx = 4'd11 - rnd_q;
                rnd_d     = rnd_q - 4'd1;
                if (rnd_q == 4'd0) begin
                    rnd_d   = 4'd0;
                    // blk_idx already counts absorbed AD blocks here
                    state_d = (blk_idx_q == ad_cnt_q) ? S_DSEP : S_AD_WAIT;
                end
            end
            S_DSEP: begin
                dsep_xor  = 1'b1;
                blk_idx_d = '0;
                state_d   = S_MSG_WAIT;
            end
            S_MSG_WAIT: begin
                blk_req = 1'b1;
                if (blk_valid && !abort_act) begin
                    absorb_msg = 1'b1;
                    blk_idx_d  = blk_idx_q + 1'b1;
                    if (mode_q == MODE_HASH) begin
                        state_d = S_MSG_PA;
                        rnd_d   = A_LOAD;
                    end else if (msg_last) begin
                        state_d = S_KHEAD;
                    end else begin
                        state_d = S_PB_MSG;
                        rnd_d   = B_LOAD;
                    end
                end
            end
            S_PB_MSG: begin
                perm_en   = 1'b1;
                round_idx = 4'd11 - rnd_q;
                rnd_d     = rnd_q - 4'd1;
                if (rnd_q == 4'd0) begin
                    rnd_d   = 4'd0;
                    state_d = S_MSG_WAIT;
                end
            end
            S_MSG_PA: begin
                perm_en   = 1'b1;
                round_idx = 4'd11 - rnd_q;
                rnd_d     = rnd_q - 4'd1;
                if (rnd_q == 4'd0) begin
                    rnd_d = 4'd0;
                    if (blk_idx_q == msg_cnt_q) begin
                        state_d   = S_SQ_WAIT;
                        blk_idx_d = '0;
                    end else begin
                        state_d = S_MSG_WAIT;
                    end
                end
            end
            S_KHEAD: begin
                key_xor_head = 1'b1;
                state_d      = S_PA_FIN;
                rnd_d        = A_LOAD;
            end
            S_PA_FIN: begin
                perm_en   = 1'b1;
                round_idx = 4'd11 - rnd_q;
                rnd_d     = rnd_q - 4'd1;
                if (rnd_q == 4'd0) begin
                    rnd_d   = 4'd0;
                    state_d = S_KTAIL_FIN;
                end
            end
            S_KTAIL_FIN: begin
                key_xor_tail = 1'b1;
                state_d      = S_DONE;
            end
            S_SQ_WAIT: begin
                squeeze = 1'b1;
                if (sq_ack && !abort_act) begin
                    blk_idx_d = blk_idx_q + 1'b1;
                    if (blk_idx_q == SQ_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SQ_PA;
                        rnd_d   = A_LOAD;
                    end
                end
            end
            S_SQ_PA: begin
                perm_en   = 1'b1;
                round_idx = 4'd11 - rnd_q;
                rnd_d     = rnd_q - 4'd1;
                if (rnd_q == 4'd0) begin
                    rnd_d   = 4'd0;
                    state_d = S_SQ_WAIT;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_act) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rnd_q     <= 4'd0;
            blk_idx_q <= '0;
            mode_q    <= 3'b000;
            ad_cnt_q  <= '0;
            msg_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            blk_idx_q <= blk_idx_d;
            mode_q    <= mode_d;
            ad_cnt_q  <= ad_cnt_d;
            msg_cnt_q <= msg_cnt_d;
            err_q     <= err_d;
        end
    end

    assign blk_idx = blk_idx_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ascon_op_sequencer.sv
module tb_ascon_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] op_mode = 3'b000;
    logic       op_start = 1'b0;
    logic [3:0] ad_blocks = 4'd0;
    logic [3:0] msg_blocks = 4'd0;
    logic       blk_valid = 1'b0;
    logic       sq_ack = 1'b0;
    logic       abort = 1'b0;
    logic       state_load, perm_en, key_xor_tail, key_xor_head, dsep_xor;
    logic       blk_req, absorb_ad, absorb_msg, squeeze, busy, done, err;
    logic [3:0] round_idx;
    logic [3:0] blk_idx;

    int n_checks = 0;
    int n_pass   = 0;

    // per-run observations
    int  t_load, t_done, t_err, busy_n, viol;
    byte ev_q[$];
    int  rnd_q[$];
    int  sqlen_q[$];
    int  sqidx_q[$];
    int  abs_idx_q[$];
    byte exp_ev[$];
    int  exp_rnd[$];

    always #5 clk = ~clk;

    ascon_op_sequencer dut (
        .clk(clk), .rst(rst), .op_mode(op_mode), .op_start(op_start),
        .ad_blocks(ad_blocks), .msg_blocks(msg_blocks), .blk_valid(blk_valid),
        .sq_ack(sq_ack), .abort(abort), .state_load(state_load), .perm_en(perm_en),
        .round_idx(round_idx), .key_xor_tail(key_xor_tail), .key_xor_head(key_xor_head),
        .dsep_xor(dsep_xor), .blk_req(blk_req), .absorb_ad(absorb_ad),
        .absorb_msg(absorb_msg), .squeeze(squeeze), .blk_idx(blk_idx), .busy(busy),
        .done(done), .err(err)
    );

    function automatic logic [19:0] all_out();
        return {state_load, perm_en, round_idx, key_xor_tail, key_xor_head, dsep_xor,
                blk_req, absorb_ad, absorb_msg, squeeze, blk_idx, busy, done, err};
    endfunction

    // Expected strobe trace: one entry per strobe cycle; perm runs of n rounds
    // use constants 12-n .. 11.
    task automatic push_run(input byte c, input int n);
        for (int i = 0; i < n; i++) begin
            exp_ev.push_back(c);
            if (c == "P") exp_rnd.push_back(12 - n + i);
        end
    endtask

    function automatic bit trace_match();
        if (ev_q.size() != exp_ev.size() || rnd_q.size() != exp_rnd.size()) return 1'b0;
        foreach (ev_q[i]) if (ev_q[i] != exp_ev[i]) return 1'b0;
        foreach (rnd_q[i]) if (rnd_q[i] != exp_rnd[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Starts one operation in the next cycle (cycle 0) with blk_valid held
    // high, acks each squeeze after sq_wait cycles, and records strobes until
    // done or max_cyc. At glitch_at, op_start is re-asserted and the
    // configuration inputs are changed to probe latching.
    task automatic run_op(input logic [2:0] mode, input logic [3:0] ad,
                          input logic [3:0] msg, input int sq_wait,
                          input int glitch_at, input int max_cyc);
        int sq_run;
        int ns;
        @(negedge clk);
        t_load = -1; t_done = -1; t_err = -1; busy_n = 0; viol = 0; sq_run = 0;
        ev_q.delete(); rnd_q.delete(); sqlen_q.delete(); sqidx_q.delete();
        abs_idx_q.delete(); exp_ev.delete(); exp_rnd.delete();
        op_mode = mode; ad_blocks = ad; msg_blocks = msg;
        op_start = 1'b1; blk_valid = 1'b1; sq_ack = 1'b0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            op_start = 1'b0;
            sq_ack   = 1'b0;
            if (k == glitch_at) begin
                op_start = 1'b1; op_mode = 3'b011; ad_blocks = 4'd5; msg_blocks = 4'd9;
            end
            ns = int'(state_load) + int'(perm_en) + int'(key_xor_tail) + int'(key_xor_head)
               + int'(dsep_xor) + int'(absorb_ad) + int'(absorb_msg);
            if (ns > 1) viol++;
            if (state_load && t_load < 0) t_load = k;
            if (busy) busy_n++;
            if (err && t_err < 0) t_err = k;
            if (state_load) ev_q.push_back("L");
            else if (perm_en) begin ev_q.push_back("P"); rnd_q.push_back(int'(round_idx)); end
            else if (key_xor_tail) ev_q.push_back("T");
            else if (key_xor_head) ev_q.push_back("H");
            else if (dsep_xor) ev_q.push_back("D");
            else if (absorb_ad) ev_q.push_back("A");
            else if (absorb_msg) ev_q.push_back("M");
            if (absorb_ad || absorb_msg) abs_idx_q.push_back(int'(blk_idx));
            if (squeeze) begin
                sq_run++;
                if (sq_run == sq_wait) begin
                    sq_ack = 1'b1;
                    sqlen_q.push_back(sq_run);
                    sqidx_q.push_back(int'(blk_idx));
                    sq_run = 0;
                end
            end
            if (done) begin
                t_done = k;
                break;
            end
        end
        blk_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_out() !== 20'd0) $display("FAIL reset_outputs: got %h want 0", all_out());
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (all_out() !== 20'd0) $display("FAIL idle_outputs: got %h want 0", all_out());
        else n_pass++;
    endtask

    task automatic test_enc_min();
        run_op(3'b001, 4'd0, 4'd1, 1, 0, 60);
        push_run("L", 1); push_run("P", 12); push_run("T", 1); push_run("D", 1);
        push_run("M", 1); push_run("H", 1); push_run("P", 12); push_run("T", 1);
        n_checks++;
        if (t_load !== 1) $display("FAIL enc_min_load: got %0d want 1", t_load);
        else n_pass++;
        n_checks++;
        if (t_done !== 31) $display("FAIL enc_min_done: got %0d want 31", t_done);
        else n_pass++;
        n_checks++;
        if (busy_n !== 30) $display("FAIL enc_min_busy: got %0d want 30", busy_n);
        else n_pass++;
        n_checks++;
        if (!trace_match()) $display("FAIL enc_min_trace: got %0d strobes want %0d", ev_q.size(), exp_ev.size());
        else n_pass++;
        n_checks++;
        if (viol !== 0) $display("FAIL enc_min_onehot: got %0d overlaps want 0", viol);
        else n_pass++;
    endtask

    task automatic test_enc_ad2_msg2();
        run_op(3'b001, 4'd2, 4'd2, 1, 0, 80);
        push_run("L", 1); push_run("P", 12); push_run("T", 1);
        push_run("A", 1); push_run("P", 6); push_run("A", 1); push_run("P", 6);
        push_run("D", 1); push_run("M", 1); push_run("P", 6); push_run("M", 1);
        push_run("H", 1); push_run("P", 12); push_run("T", 1);
        n_checks++;
        if (!trace_match()) $display("FAIL enc_ad2_trace: got %0d strobes want %0d", ev_q.size(), exp_ev.size());
        else n_pass++;
        // 31 for the minimal op plus two AD blocks and one extra msg block, 7 cycles each
        n_checks++;
        if (t_done !== 52) $display("FAIL enc_ad2_done: got %0d want 52", t_done);
        else n_pass++;
        n_checks++;
        if (abs_idx_q.size() != 4 || abs_idx_q[0] != 0 || abs_idx_q[1] != 1 ||
            abs_idx_q[2] != 0 || abs_idx_q[3] != 1)
            $display("FAIL enc_ad2_blk_idx: got %0d absorbs want idx 0,1,0,1", abs_idx_q.size());
        else n_pass++;
        n_checks++;
        if (viol !== 0) $display("FAIL enc_ad2_onehot: got %0d overlaps want 0", viol);
        else n_pass++;
    endtask

    task automatic test_dec();
        run_op(3'b010, 4'd1, 4'd1, 1, 0, 60);
        n_checks++;
        if (t_done !== 38) $display("FAIL dec_done: got %0d want 38", t_done);
        else n_pass++;
    endtask

    task automatic test_hash();
        run_op(3'b011, 4'd0, 4'd1, 5, 0, 200);
        push_run("L", 1); push_run("P", 12); push_run("M", 1); push_run("P", 12);
        push_run("P", 12); push_run("P", 12); push_run("P", 12);
        n_checks++;
        if (!trace_match()) $display("FAIL hash_trace: got %0d strobes want %0d", ev_q.size(), exp_ev.size());
        else n_pass++;
        n_checks++;
        if (t_done !== 83) $display("FAIL hash_done: got %0d want 83", t_done);
        else n_pass++;
        n_checks++;
        if (sqlen_q.size() != 4 || sqlen_q[0] != 5 || sqlen_q[1] != 5 ||
            sqlen_q[2] != 5 || sqlen_q[3] != 5)
            $display("FAIL hash_squeeze_len: got %0d blocks want 4 of 5 cycles", sqlen_q.size());
        else n_pass++;
        n_checks++;
        if (sqidx_q.size() != 4 || sqidx_q[0] != 0 || sqidx_q[1] != 1 ||
            sqidx_q[2] != 2 || sqidx_q[3] != 3)
            $display("FAIL hash_squeeze_idx: got %0d blocks want idx 0..3", sqidx_q.size());
        else n_pass++;
    endtask

    task automatic test_perm_back_to_back();
        run_op(3'b100, 4'd0, 4'd0, 1, 0, 30);
        push_run("P", 12);
        n_checks++;
        if (!trace_match() || t_load !== -1) $display("FAIL perm_trace: got %0d strobes load %0d want 12 no load", ev_q.size(), t_load);
        else n_pass++;
        n_checks++;
        if (t_done !== 13) $display("FAIL perm_done: got %0d want 13", t_done);
        else n_pass++;
        // start in the cycle right after DONE
        run_op(3'b001, 4'd0, 4'd1, 1, 0, 60);
        n_checks++;
        if (t_load !== 1 || t_done !== 31) $display("FAIL back_to_back: got load %0d done %0d want 1 31", t_load, t_done);
        else n_pass++;
    endtask

    task automatic test_illegal();
        logic [2:0] modes [4];
        logic [3:0] msgs [4];
        modes[0] = 3'b111; msgs[0] = 4'd1;
        modes[1] = 3'b000; msgs[1] = 4'd1;
        modes[2] = 3'b001; msgs[2] = 4'd0;
        modes[3] = 3'b011; msgs[3] = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op_mode = modes[i]; msg_blocks = msgs[i]; ad_blocks = 4'd0; op_start = 1'b1;
            @(negedge clk);
            op_start = 1'b0;
            n_checks++;
            if (err !== 1'b1 || busy !== 1'b0 || state_load !== 1'b0)
                $display("FAIL illegal_%0d: got err %b busy %b want err 1 busy 0", i, err, busy);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (err !== 1'b0 || busy !== 1'b0)
                $display("FAIL illegal_%0d_after: got err %b busy %b want 0 0", i, err, busy);
            else n_pass++;
        end
    endtask

    task automatic test_ignore_start();
        run_op(3'b001, 4'd0, 4'd1, 1, 5, 60);
        push_run("L", 1); push_run("P", 12); push_run("T", 1); push_run("D", 1);
        push_run("M", 1); push_run("H", 1); push_run("P", 12); push_run("T", 1);
        n_checks++;
        if (t_done !== 31 || t_err !== -1) $display("FAIL busy_start: got done %0d err %0d want 31 -1", t_done, t_err);
        else n_pass++;
        n_checks++;
        if (!trace_match()) $display("FAIL latched_cfg: got %0d strobes want %0d", ev_q.size(), exp_ev.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op_mode = 3'b001; ad_blocks = 4'd1; msg_blocks = 4'd1; blk_valid = 1'b1; op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        repeat (17) @(negedge clk);
        // cycle 18 is inside the AD p^b run (cycles 16..21)
        n_checks++;
        if (perm_en !== 1'b1 || round_idx !== 4'd8)
            $display("FAIL mid_pb: got perm %b idx %0d want 1 8", perm_en, round_idx);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (all_out() !== 20'd0) $display("FAIL reset_mid: got %h want 0", all_out());
        else n_pass++;
        rst = 1'b0;
        blk_valid = 1'b0;
    endtask

    task automatic test_abort();
        int k;
        @(negedge clk);
        op_mode = 3'b001; ad_blocks = 4'd0; msg_blocks = 4'd1; blk_valid = 1'b0; op_start = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            op_start = 1'b0;
            k++;
        end while (!blk_req && k < 40);
        n_checks++;
        if (k !== 16) $display("FAIL abort_reach_wait: got cycle %0d want 16", k);
        else n_pass++;
        abort = 1'b1; blk_valid = 1'b1;
        #1;
`ifdef ASCON_SEQ_ABORT_EN
        n_checks++;
        if (absorb_msg !== 1'b0) $display("FAIL abort_absorb: got %b want 0", absorb_msg);
        else n_pass++;
        @(negedge clk);
        abort = 1'b0; blk_valid = 1'b0;
        n_checks++;
        if (all_out() !== 20'd0) $display("FAIL abort_idle: got %h want 0", all_out());
        else n_pass++;
`else
        n_checks++;
        if (absorb_msg !== 1'b1) $display("FAIL abort_ignored_absorb: got %b want 1", absorb_msg);
        else n_pass++;
        @(negedge clk);
        abort = 1'b0; blk_valid = 1'b0;
        n_checks++;
        if (key_xor_head !== 1'b1 || busy !== 1'b1)
            $display("FAIL abort_ignored_next: got khead %b busy %b want 1 1", key_xor_head, busy);
        else n_pass++;
        k = 0;
        while (!done && k < 30) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k !== 14) $display("FAIL abort_ignored_done: got %0d want 14", k);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_enc_min();
        test_enc_ad2_msg2();
        test_dec();
        test_hash();
        test_perm_back_to_back();
        test_illegal();
        test_ignore_start();
        test_reset_mid();
        test_abort();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
